// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and spi_controller signal bundle for spi_arbiter
interface spi_arbiter_if;
  logic [1:0] req;
  logic [1:0] wr;
  logic [1:0] rd;
  logic [7:0] din0;
  logic [7:0] din1;
  logic [1:0] ignore_resp;
  logic [1:0] grant;
  logic [1:0] wr_ack;
  logic [1:0] rvalid;
  logic [7:0] rdata;
  logic       spi_wr;
  logic       spi_rd;
  logic [7:0] spi_din;
  logic       spi_ignore_response;
  logic       spi_buffer_full;
  logic       spi_buffer_empty;
  logic       spi_data_avail;
  logic [7:0] spi_dout;

  // Environment side: the two requesters plus the spi_controller status/data.
  modport master (
    output req, wr, rd, din0, din1, ignore_resp,
    output spi_buffer_full, spi_buffer_empty, spi_data_avail, spi_dout,
    input  grant, wr_ack, rvalid, rdata,
    input  spi_wr, spi_rd, spi_din, spi_ignore_response
  );

  // Arbiter side.
  modport slave (
    input  req, wr, rd, din0, din1, ignore_resp,
    input  spi_buffer_full, spi_buffer_empty, spi_data_avail, spi_dout,
    output grant, wr_ack, rvalid, rdata,
    output spi_wr, spi_rd, spi_din, spi_ignore_response
  );
endinterface

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester transaction-locking arbiter in front of spi_controller
module spi_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_arbiter_if.slave bus,
  output logic         timeout_flag,
  input  logic         timeout_clr
);
  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          rr;
  logic          owner;
  logic [CW-1:0] idle_cnt;
  logic          grant_take;
  logic          grant_pick;
  logic          wr_acc;
  logic          rd_acc;
  logic          drain_rd;
  logic          tmo_set;
  logic          release_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes; the registered spi_wr/spi_rd
  // pulses block a second accept of the same byte on the following cycle.
  always_comb begin
    state_nxt    = state;
    grant_take   = 1'b0;
    grant_pick   = rr;
    wr_acc       = 1'b0;
    rd_acc       = 1'b0;
    drain_rd     = 1'b0;
    tmo_set      = 1'b0;
    release_done = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_take = 1'b1;
          grant_pick = bus.req[rr] ? rr : ~rr;
          state_nxt  = OWN;
        end
      end
      OWN: begin
        if (!bus.req[owner]) begin
          state_nxt = DRAIN;
        end else if (idle_cnt == CNT_MAX) begin
          tmo_set   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          wr_acc = bus.wr[owner] & !bus.spi_buffer_full & !bus.spi_wr;
          rd_acc = bus.rd[owner] & bus.spi_data_avail & !bus.spi_rd & !wr_acc;
        end
      end
      DRAIN: begin
        if (bus.spi_buffer_empty & !bus.spi_data_avail & !bus.spi_rd & !bus.spi_wr) begin
          release_done = 1'b1;
          state_nxt    = IDLE;
        end else begin
          drain_rd = bus.spi_data_avail & !bus.spi_rd;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership, round-robin pointer and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.grant <= 2'b00;
      owner     <= 1'b0;
      rr        <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      if (grant_take) begin
        owner     <= grant_pick;
        bus.grant <= grant_pick ? 2'b10 : 2'b01;
      end else if (state_nxt != OWN) begin
        bus.grant <= 2'b00;
      end
      if (release_done) rr <= ~owner;
      if (grant_take | wr_acc | rd_acc)          idle_cnt <= '0;
      else if (state == OWN && idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + CW'(1);
    end
  end

  // Registered command pulses toward spi_controller and acks toward the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_ack              <= 2'b00;
      bus.rvalid              <= 2'b00;
      bus.rdata               <= 8'h00;
      bus.spi_wr              <= 1'b0;
      bus.spi_rd              <= 1'b0;
      bus.spi_din             <= 8'h00;
      bus.spi_ignore_response <= 1'b0;
    end else begin
      bus.wr_ack <= 2'b00;
      bus.rvalid <= 2'b00;
      bus.spi_wr <= 1'b0;
      bus.spi_rd <= 1'b0;
      if (wr_acc) begin
        bus.spi_wr              <= 1'b1;
        bus.spi_din             <= owner ? bus.din1 : bus.din0;
        bus.spi_ignore_response <= bus.ignore_resp[owner];
        bus.wr_ack              <= owner ? 2'b10 : 2'b01;
      end
      if (rd_acc) begin
        bus.spi_rd <= 1'b1;
        bus.rdata  <= bus.spi_dout;
        bus.rvalid <= owner ? 2'b10 : 2'b01;
      end
      if (drain_rd) bus.spi_rd <= 1'b1;
    end
  end

  // Sticky forced-release flag; a set in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timeout_flag <= 1'b0;
    else if (tmo_set)     timeout_flag <= 1'b1;
    else if (timeout_clr) timeout_flag <= 1'b0;
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
module tb_spi_arbiter;
  logic clk;
  logic rst_n;
  logic timeout_flag;
  logic timeout_clr;
  int   checks;
  int   failures;
  int   n_spi_wr, n_spi_rd, n_ack0, n_ack1, n_rv0, n_rv1;

  spi_arbiter_if bus ();

  spi_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    n_spi_wr += int'(bus.spi_wr);
    n_spi_rd += int'(bus.spi_rd);
    n_ack0   += int'(bus.wr_ack[0]);
    n_ack1   += int'(bus.wr_ack[1]);
    n_rv0    += int'(bus.rvalid[0]);
    n_rv1    += int'(bus.rvalid[1]);
  endtask

  task automatic clr_counts();
    n_spi_wr = 0; n_spi_rd = 0; n_ack0 = 0; n_ack1 = 0; n_rv0 = 0; n_rv1 = 0;
  endtask

  task automatic do_reset();
    bus.req = 2'b00; bus.wr = 2'b00; bus.rd = 2'b00;
    bus.din0 = 8'h00; bus.din1 = 8'h00; bus.ignore_resp = 2'b00;
    bus.spi_buffer_full = 1'b0; bus.spi_buffer_empty = 1'b1;
    bus.spi_data_avail = 1'b0; bus.spi_dout = 8'h00;
    timeout_clr = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    clr_counts();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
    checks++; if (bus.wr_ack !== 2'b00 || bus.rvalid !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b/%b exp=00/00", bus.wr_ack, bus.rvalid); end
    checks++; if (bus.rdata !== 8'h00 || bus.spi_din !== 8'h00) begin failures++; $display("FAIL reset_data got=%h/%h exp=00/00", bus.rdata, bus.spi_din); end
    checks++; if (bus.spi_wr !== 1'b0 || bus.spi_rd !== 1'b0 || bus.spi_ignore_response !== 1'b0) begin failures++; $display("FAIL reset_spi got=%b%b%b exp=000", bus.spi_wr, bus.spi_rd, bus.spi_ignore_response); end
    checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", timeout_flag); end
  endtask

  task automatic test_single_owner();
    do_reset();
    bus.req = 2'b01;
    step();
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL so_grant got=%b exp=01", bus.grant); end
    bus.wr = 2'b01; bus.din0 = 8'hA5;
    step();
    checks++; if (bus.spi_wr !== 1'b1 || bus.spi_din !== 8'hA5 || bus.wr_ack !== 2'b01) begin failures++; $display("FAIL so_wr1 got=%b %h %b exp=1 a5 01", bus.spi_wr, bus.spi_din, bus.wr_ack); end
    step();
    checks++; if (bus.spi_wr !== 1'b0 || bus.wr_ack !== 2'b00) begin failures++; $display("FAIL so_no_double got=%b %b exp=0 00", bus.spi_wr, bus.wr_ack); end
    bus.din0 = 8'h3C;
    step();
    checks++; if (bus.spi_wr !== 1'b1 || bus.spi_din !== 8'h3C || bus.wr_ack !== 2'b01) begin failures++; $display("FAIL so_wr2 got=%b %h %b exp=1 3c 01", bus.spi_wr, bus.spi_din, bus.wr_ack); end
    bus.wr = 2'b00;
    step();
    checks++; if (n_spi_wr !== 2 || n_ack0 !== 2 || n_ack1 !== 0) begin failures++; $display("FAIL so_counts got=%0d/%0d/%0d exp=2/2/0", n_spi_wr, n_ack0, n_ack1); end
    bus.req = 2'b00;
    step();
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL so_release got=%b exp=00", bus.grant); end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 2'b11;
    step();
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", bus.grant); end
    step();
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL rr_hold got=%b exp=01", bus.grant); end
    bus.req = 2'b10;
    step();
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL rr_drain got=%b exp=00", bus.grant); end
    step();
    step();
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL rr_second got=%b exp=10", bus.grant); end
    bus.req = 2'b11;
    step(); step(); step();
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL rr_wait got=%b exp=10", bus.grant); end
    bus.req = 2'b01;
    step(); step(); step();
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL rr_back got=%b exp=01", bus.grant); end
    bus.req = 2'b00;
    step(); step();
  endtask

  task automatic test_backpressure_read();
    int busy_hits;
    do_reset();
    bus.req = 2'b10;
    step();
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", bus.grant); end
    bus.spi_buffer_full = 1'b1;
    bus.wr = 2'b10; bus.din1 = 8'h77; bus.ignore_resp = 2'b10;
    busy_hits = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.spi_wr !== 1'b0 || bus.wr_ack !== 2'b00) busy_hits++;
    end
    checks++; if (busy_hits !== 0) begin failures++; $display("FAIL bp_full_block got=%0d exp=0", busy_hits); end
    bus.spi_buffer_full = 1'b0;
    step();
    checks++; if (bus.spi_wr !== 1'b1 || bus.spi_din !== 8'h77 || bus.spi_ignore_response !== 1'b1 || bus.wr_ack !== 2'b10) begin failures++; $display("FAIL bp_write got=%b %h %b %b exp=1 77 1 10", bus.spi_wr, bus.spi_din, bus.spi_ignore_response, bus.wr_ack); end
    bus.wr = 2'b00;
    bus.spi_data_avail = 1'b1; bus.spi_buffer_empty = 1'b0; bus.spi_dout = 8'h5E;
    bus.rd = 2'b10;
    clr_counts();
    step();
    checks++; if (bus.spi_rd !== 1'b1 || bus.rvalid !== 2'b10 || bus.rdata !== 8'h5E) begin failures++; $display("FAIL bp_read got=%b %b %h exp=1 10 5e", bus.spi_rd, bus.rvalid, bus.rdata); end
    step();
    bus.rd = 2'b00; bus.spi_dout = 8'h00;
    checks++; if (n_spi_rd !== 1 || n_rv1 !== 1 || n_rv0 !== 0) begin failures++; $display("FAIL bp_single_pop got=%0d/%0d/%0d exp=1/1/0", n_spi_rd, n_rv1, n_rv0); end
    bus.wr = 2'b01; bus.rd = 2'b01;
    step();
    checks++; if (bus.spi_wr !== 1'b0 || bus.spi_rd !== 1'b0 || bus.wr_ack !== 2'b00 || bus.rvalid !== 2'b00) begin failures++; $display("FAIL bp_nonowner got=%b%b %b %b exp=00 00 00", bus.spi_wr, bus.spi_rd, bus.wr_ack, bus.rvalid); end
    bus.wr = 2'b00; bus.rd = 2'b00;
    bus.spi_data_avail = 1'b0; bus.spi_buffer_empty = 1'b1;
    bus.req = 2'b00;
    step(); step();
  endtask

  task automatic test_drain_flush();
    int pending;
    int early;
    int found;
    do_reset();
    bus.req = 2'b01;
    step();
    bus.spi_data_avail = 1'b1; bus.spi_buffer_empty = 1'b0;
    pending = 2;
    bus.req = 2'b00;
    clr_counts();
    step();
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL dr_grant_off got=%b exp=00", bus.grant); end
    bus.req = 2'b10;
    early = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.spi_rd === 1'b1 && pending > 0) pending--;
      bus.spi_data_avail   = (pending > 0);
      bus.spi_buffer_empty = (pending == 0);
      if (bus.grant !== 2'b00) begin
        if (pending != 0) early = 1;
        found = 1;
        break;
      end
    end
    checks++; if (found !== 1) begin failures++; $display("FAIL dr_regrant_timeout got=%0d exp=1", found); end
    checks++; if (n_spi_rd !== 2) begin failures++; $display("FAIL dr_pops got=%0d exp=2", n_spi_rd); end
    checks++; if (n_rv0 + n_rv1 !== 0) begin failures++; $display("FAIL dr_rvalid got=%0d exp=0", n_rv0 + n_rv1); end
    checks++; if (early !== 0) begin failures++; $display("FAIL dr_early_idle got=%0d exp=0", early); end
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL dr_next_owner got=%b exp=10", bus.grant); end
    bus.req = 2'b00;
    step(); step();
  endtask

  task automatic test_timeout();
    int drop_at;
    do_reset();
    bus.req = 2'b10;
    step();
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL to_grant got=%b exp=10", bus.grant); end
    drop_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.grant === 2'b00) begin
        drop_at = k;
        break;
      end
    end
    checks++; if (drop_at !== 17) begin failures++; $display("FAIL to_drop_cycle got=%0d exp=17", drop_at); end
    checks++; if (timeout_flag !== 1'b1) begin failures++; $display("FAIL to_flag_set got=%b exp=1", timeout_flag); end
    step();
    checks++; if (timeout_flag !== 1'b1) begin failures++; $display("FAIL to_flag_sticky got=%b exp=1", timeout_flag); end
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    checks++; if (timeout_flag !== 1'b0 || bus.grant !== 2'b10) begin failures++; $display("FAIL to_clear got=%b %b exp=0 10", timeout_flag, bus.grant); end
    for (int k = 0; k < 16; k++) step();
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    checks++; if (timeout_flag !== 1'b1 || bus.grant !== 2'b00) begin failures++; $display("FAIL to_set_wins got=%b %b exp=1 00", timeout_flag, bus.grant); end
    bus.req = 2'b00;
    step(); step();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    step(); step();
    bus.req = 2'b10;
    step();
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL ar_pre_grant got=%b exp=10", bus.grant); end
    bus.wr = 2'b10; bus.din1 = 8'h42;
    step();
    checks++; if (bus.spi_wr !== 1'b1 || bus.wr_ack !== 2'b10) begin failures++; $display("FAIL ar_pre_write got=%b %b exp=1 10", bus.spi_wr, bus.wr_ack); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL ar_grant got=%b exp=00", bus.grant); end
    checks++; if (bus.spi_wr !== 1'b0 || bus.spi_rd !== 1'b0 || bus.wr_ack !== 2'b00 || bus.rvalid !== 2'b00 || timeout_flag !== 1'b0) begin failures++; $display("FAIL ar_outputs got=%b%b %b %b %b exp=00 00 00 0", bus.spi_wr, bus.spi_rd, bus.wr_ack, bus.rvalid, timeout_flag); end
    bus.wr = 2'b00;
    @(negedge clk);
    bus.req = 2'b11;
    rst_n = 1'b1;
    step();
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL ar_rr_restart got=%b exp=01", bus.grant); end
    bus.req = 2'b00;
    step(); step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clr_counts();
    test_reset();
    test_single_owner();
    test_round_robin();
    test_backpressure_read();
    test_drain_flush();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
